// File: rtl/pll_pkg.sv
// ---------------------------------------------------------------------------
// pll_pkg : shared types and default timing for the PLL sequencer
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package pll_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_RESET  = 3'd0,
    ST_WAIT   = 3'd1,
    ST_STABLE = 3'd2,
    ST_RUN    = 3'd3,
    ST_FAIL   = 3'd4
  } pll_state_e;

  // Defaults for a 27 MHz reference clock
  localparam int DEF_RST_CYCLES   = 27;
  localparam int DEF_LOCK_TIMEOUT = 27000;
  localparam int DEF_LOCK_STABLE  = 256;
  localparam int DEF_MAX_RETRY    = 3;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

`default_nettype wire

// File: rtl/sync_2ff.sv
// ---------------------------------------------------------------------------
// sync_2ff : generic two-flop synchroniser for asynchronous status inputs
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_q, meta_d;
  logic [WIDTH-1:0] sync_q, sync_d;

  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule

`default_nettype wire

// File: rtl/pll_seq_ctrl.sv
// ---------------------------------------------------------------------------
// pll_seq_ctrl : PLL power-up / recovery sequencer with retry and sticky fail
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module pll_seq_ctrl
  import pll_pkg::*;
#(
  parameter int RST_CYCLES   = DEF_RST_CYCLES,
  parameter int LOCK_TIMEOUT = DEF_LOCK_TIMEOUT,
  parameter int LOCK_STABLE  = DEF_LOCK_STABLE,
  parameter int MAX_RETRY    = DEF_MAX_RETRY
) (
  input  logic               clkin,
  input  logic               reset,
  input  logic               lock,
  input  logic               restart,
  output logic               pll_reset,
  output logic               ready,
  output logic               fail,
  output logic [2:0]         retry_cnt,
  output logic [7:0]         loss_cnt,
  output logic [STATE_W-1:0] state
);

  localparam int CNT_W = $clog2(max3(RST_CYCLES, LOCK_TIMEOUT, LOCK_STABLE)) + 1;

  localparam logic [CNT_W-1:0] C_CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] C_RST_LAST  = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] C_TMO_LAST  = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] C_STB_LAST  = CNT_W'(LOCK_STABLE - 1);
  localparam logic [2:0]       C_MAX_RETRY = 3'(MAX_RETRY);

  logic             lock_s;
  pll_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] tmo_q, tmo_d;
  logic [2:0]       retry_q, retry_d;
  logic [7:0]       loss_q, loss_d;
  logic             pll_reset_q, pll_reset_d;
  logic             ready_q, ready_d;
  logic             fail_q, fail_d;
  logic             timeout;
  logic [2:0]       retry_inc;

  sync_2ff #(
    .WIDTH (1)
  ) u_lock_sync (
    .clk (clkin),
    .rst (reset),
    .d   (lock),
    .q   (lock_s)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    tmo_d     = tmo_q;
    retry_d   = retry_q;
    loss_d    = loss_q;
    retry_inc = retry_q + 3'd1;
    timeout   = ((state_q == ST_WAIT) || (state_q == ST_STABLE)) && (tmo_q == C_TMO_LAST);

    if (restart) begin
      state_d = ST_RESET;
      cnt_d   = '0;
      tmo_d   = '0;
      retry_d = '0;
    end else if (timeout) begin
      // Timeout outranks a lock_s edge seen in the same cycle
      retry_d = retry_inc;
      cnt_d   = '0;
      tmo_d   = '0;
      state_d = (retry_inc == C_MAX_RETRY) ? ST_FAIL : ST_RESET;
    end else begin
      case (state_q)
        ST_RESET: begin
          if (cnt_q == C_RST_LAST) begin
            state_d = ST_WAIT;
            cnt_d   = '0;
            tmo_d   = '0;
          end else begin
            cnt_d = cnt_q + C_CNT_ONE;
          end
        end
        ST_WAIT: begin
          tmo_d = tmo_q + C_CNT_ONE;
          if (lock_s) begin
            state_d = ST_STABLE;
            cnt_d   = '0;
          end
        end
        ST_STABLE: begin
          // tmo keeps running across STABLE->WAIT bounces
          tmo_d = tmo_q + C_CNT_ONE;
          if (!lock_s) begin
            state_d = ST_WAIT;
            cnt_d   = '0;
          end else if (cnt_q == C_STB_LAST) begin
            state_d = ST_RUN;
            retry_d = '0;
          end else begin
            cnt_d = cnt_q + C_CNT_ONE;
          end
        end
        ST_RUN: begin
          if (!lock_s) begin
            state_d = ST_RESET;
            cnt_d   = '0;
            tmo_d   = '0;
            if (loss_q != 8'hFF) begin
              loss_d = loss_q + 8'd1;
            end
          end
        end
        ST_FAIL: begin
          state_d = ST_FAIL;
        end
        default: begin
          state_d = ST_RESET;
          cnt_d   = '0;
          tmo_d   = '0;
        end
      endcase
    end

    pll_reset_d = (state_d == ST_RESET) || (state_d == ST_FAIL);
    ready_d     = (state_d == ST_RUN);
    fail_d      = (state_d == ST_FAIL);
  end

  always_ff @(posedge clkin) begin
    if (reset) begin
      state_q     <= ST_RESET;
      cnt_q       <= '0;
      tmo_q       <= '0;
      retry_q     <= '0;
      loss_q      <= '0;
      pll_reset_q <= 1'b1;
      ready_q     <= 1'b0;
      fail_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      tmo_q       <= tmo_d;
      retry_q     <= retry_d;
      loss_q      <= loss_d;
      pll_reset_q <= pll_reset_d;
      ready_q     <= ready_d;
      fail_q      <= fail_d;
    end
  end

  assign pll_reset = pll_reset_q;
  assign ready     = ready_q;
  assign fail      = fail_q;
  assign retry_cnt = retry_q;
  assign loss_cnt  = loss_q;
  assign state     = state_q;

endmodule

`default_nettype wire

// File: tb/tb_pll_seq_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pll_seq_ctrl : directed vector bench for pll_seq_ctrl
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_pll_seq_ctrl;

  localparam logic [2:0] S_RESET  = 3'd0;
  localparam logic [2:0] S_WAIT   = 3'd1;
  localparam logic [2:0] S_STABLE = 3'd2;
  localparam logic [2:0] S_RUN    = 3'd3;
  localparam logic [2:0] S_FAIL   = 3'd4;

  logic       clkin   = 1'b0;
  logic       reset   = 1'b1;
  logic       lock    = 1'b0;
  logic       restart = 1'b0;
  logic       pll_reset;
  logic       ready;
  logic       fail;
  logic [2:0] retry_cnt;
  logic [7:0] loss_cnt;
  logic [2:0] state;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clkin = ~clkin;

  pll_seq_ctrl #(
    .RST_CYCLES   (4),
    .LOCK_TIMEOUT (20),
    .LOCK_STABLE  (8),
    .MAX_RETRY    (3)
  ) dut (
    .clkin     (clkin),
    .reset     (reset),
    .lock      (lock),
    .restart   (restart),
    .pll_reset (pll_reset),
    .ready     (ready),
    .fail      (fail),
    .retry_cnt (retry_cnt),
    .loss_cnt  (loss_cnt),
    .state     (state)
  );

  typedef struct {
    int         cyc;
    logic       rst;
    logic       lk;
    logic       rs;
    logic [2:0] st;
    logic       pr;
    logic       rd;
    logic       fl;
    logic [2:0] rc;
    logic [7:0] lc;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input int c, input logic r, input logic l, input logic s,
                     input logic [2:0] st, input logic pr, input logic rd,
                     input logic fl, input logic [2:0] rc, input logic [7:0] lc);
    vec_t t;
    t.cyc = c; t.rst = r; t.lk = l; t.rs = s;
    t.st = st; t.pr = pr; t.rd = rd; t.fl = fl; t.rc = rc; t.lc = lc;
    vecs.push_back(t);
  endtask

  task automatic check(input string name, input logic [2:0] st, input logic pr,
                       input logic rd, input logic fl, input logic [2:0] rc,
                       input logic [7:0] lc);
    n_cmp++;
    if ({state, pll_reset, ready, fail, retry_cnt, loss_cnt} !== {st, pr, rd, fl, rc, lc}) begin
      n_bad++;
      $display("FAIL %s: got state=%0d pll_reset=%0b ready=%0b fail=%0b retry=%0d loss=%0d, want state=%0d pll_reset=%0b ready=%0b fail=%0b retry=%0d loss=%0d",
               name, state, pll_reset, ready, fail, retry_cnt, loss_cnt, st, pr, rd, fl, rc, lc);
    end
  endtask

  initial begin
    //   cyc rst lk rs  state    pr rd fl rc lc
    add(3,  1, 0, 0, S_RESET,  1, 0, 0, 0, 0);   // reset values
    add(3,  0, 0, 0, S_RESET,  1, 0, 0, 0, 0);
    add(1,  0, 0, 0, S_WAIT,   0, 0, 0, 0, 0);   // pll_reset high exactly 4
    add(3,  0, 0, 0, S_WAIT,   0, 0, 0, 0, 0);
    add(2,  0, 1, 0, S_WAIT,   0, 0, 0, 0, 0);   // synchroniser delay
    add(1,  0, 1, 0, S_STABLE, 0, 0, 0, 0, 0);
    add(7,  0, 1, 0, S_STABLE, 0, 0, 0, 0, 0);
    add(1,  0, 1, 0, S_RUN,    0, 1, 0, 0, 0);   // ready: 2 + 9 after lock
    add(2,  0, 0, 0, S_RUN,    0, 1, 0, 0, 0);
    add(1,  0, 0, 0, S_RESET,  1, 0, 0, 0, 1);   // lock loss
    add(3,  0, 1, 0, S_RESET,  1, 0, 0, 0, 1);
    add(1,  0, 1, 0, S_WAIT,   0, 0, 0, 0, 1);
    add(1,  0, 1, 0, S_STABLE, 0, 0, 0, 0, 1);
    add(3,  0, 1, 0, S_STABLE, 0, 0, 0, 0, 1);
    add(1,  0, 0, 0, S_STABLE, 0, 0, 0, 0, 1);   // one-cycle glitch
    add(2,  0, 1, 0, S_WAIT,   0, 0, 0, 0, 1);
    add(1,  0, 1, 0, S_STABLE, 0, 0, 0, 0, 1);
    add(7,  0, 1, 0, S_STABLE, 0, 0, 0, 0, 1);
    add(1,  0, 1, 0, S_RUN,    0, 1, 0, 0, 1);   // no timeout after relock
    add(2,  0, 0, 0, S_RUN,    0, 1, 0, 0, 1);
    add(1,  0, 0, 1, S_RESET,  1, 0, 0, 0, 1);   // restart beats loss
    add(3,  0, 0, 0, S_RESET,  1, 0, 0, 0, 1);
    add(1,  0, 0, 0, S_WAIT,   0, 0, 0, 0, 1);
    add(19, 0, 0, 0, S_WAIT,   0, 0, 0, 0, 1);
    add(1,  0, 0, 0, S_RESET,  1, 0, 0, 1, 1);   // timeout 1
    add(4,  0, 0, 0, S_WAIT,   0, 0, 0, 1, 1);
    add(20, 0, 0, 0, S_RESET,  1, 0, 0, 2, 1);   // timeout 2
    add(4,  0, 0, 0, S_WAIT,   0, 0, 0, 2, 1);
    add(19, 0, 0, 0, S_WAIT,   0, 0, 0, 2, 1);
    add(1,  0, 0, 0, S_FAIL,   1, 0, 1, 3, 1);   // timeout 3 -> FAIL
    add(30, 0, 0, 0, S_FAIL,   1, 0, 1, 3, 1);
    add(1,  0, 0, 1, S_RESET,  1, 0, 0, 0, 1);   // restart from FAIL
    add(3,  0, 0, 0, S_RESET,  1, 0, 0, 0, 1);
    add(1,  0, 0, 0, S_WAIT,   0, 0, 0, 0, 1);
    add(2,  0, 1, 0, S_WAIT,   0, 0, 0, 0, 1);
    add(1,  0, 1, 0, S_STABLE, 0, 0, 0, 0, 1);
    add(1,  1, 1, 0, S_RESET,  1, 0, 0, 0, 0);   // reset during STABLE
    add(3,  0, 0, 0, S_RESET,  1, 0, 0, 0, 0);
    add(1,  0, 0, 0, S_WAIT,   0, 0, 0, 0, 0);
    add(17, 0, 0, 0, S_WAIT,   0, 0, 0, 0, 0);
    add(2,  0, 1, 0, S_WAIT,   0, 0, 0, 0, 0);
    add(1,  0, 1, 0, S_RESET,  1, 0, 0, 1, 0);   // timeout beats lock rise
    add(3,  0, 1, 0, S_RESET,  1, 0, 0, 1, 0);
    add(1,  0, 1, 0, S_WAIT,   0, 0, 0, 1, 0);
    add(1,  0, 1, 0, S_STABLE, 0, 0, 0, 1, 0);
    add(8,  0, 1, 0, S_RUN,    0, 1, 0, 0, 0);   // retry cleared in RUN

    for (int i = 0; i < vecs.size(); i++) begin
      reset   = vecs[i].rst;
      lock    = vecs[i].lk;
      restart = vecs[i].rs;
      repeat (vecs[i].cyc) @(posedge clkin);
      #1;
      check($sformatf("row%0d", i), vecs[i].st, vecs[i].pr, vecs[i].rd,
            vecs[i].fl, vecs[i].rc, vecs[i].lc);
    end

    // 256 lock drops in RUN: loss_cnt must stop at 255
    for (int i = 0; i < 256; i++) begin
      lock = 1'b0;
      repeat (3) @(posedge clkin);
      #1;
      check($sformatf("drop%0d", i), S_RESET, 1'b1, 1'b0, 1'b0, 3'd0,
            (i >= 254) ? 8'd255 : 8'(i + 1));
      lock = 1'b1;
      repeat (13) @(posedge clkin);
      #1;
      check($sformatf("relock%0d", i), S_RUN, 1'b0, 1'b1, 1'b0, 3'd0,
            (i >= 254) ? 8'd255 : 8'(i + 1));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
